// File: rtl/id_module.sv
// id_module: ARM-subset decode stage with register file, condition check and RAW stall.
// Define FORWARDING_EN to limit the stall to load-use against the EXE stage.
module id_module #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [31:0]       Instruction,
    input  logic [3:0]        SR,
    input  logic              WB_WB_EN,
    input  logic [3:0]        WB_Dest,
    input  logic [DATA_W-1:0] WB_Value,
    input  logic              EXE_WB_EN,
    input  logic              MEM_WB_EN,
    input  logic [3:0]        EXE_Dest,
    input  logic [3:0]        MEM_Dest,
    input  logic              EXE_MEM_R_EN,
    output logic              hazard,
    output logic [DATA_W-1:0] PC,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              B,
    output logic              S,
    output logic [3:0]        EXE_CMD,
    output logic [DATA_W-1:0] Val_Rn,
    output logic [DATA_W-1:0] Val_Rm,
    output logic              imm,
    output logic [11:0]       Shift_operand,
    output logic [23:0]       Signed_imm_24,
    output logic [3:0]        Dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2
);

    localparam logic [3:0] LAST_REG = 4'(NUM_REGS - 1);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic              wb_en;
        logic              mem_r;
        logic              mem_w;
        logic              b;
        logic              s;
        logic [3:0]        cmd;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic              imm;
        logic [11:0]       shift;
        logic [23:0]       simm;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
    } id_ex_t;

    logic [DATA_W-1:0] rf_q [NUM_REGS];
    id_ex_t            id_ex_d;
    id_ex_t            id_ex_q;

    logic [3:0]        cond;
    logic [3:0]        opcode;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [3:0]        src2_sel;
    logic [1:0]        mode;
    logic              i_bit;
    logic              s_bit;
    logic              is_dp;
    logic              is_mem;
    logic              is_br;
    logic              is_str;
    logic              cond_ok;
    logic              rn_used;
    logic              two_src;
    logic [3:0]        alu_cmd;
    logic [3:0]        exe_cmd;
    logic              wb_en;
    logic              mem_r;
    logic              mem_w;
    logic              br;
    logic              s_out;
    logic              hit1;
    logic              hit2;
    logic              raw;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              fl_n;
    logic              fl_z;
    logic              fl_c;
    logic              fl_v;

    assign cond     = Instruction[31:28];
    assign mode     = Instruction[27:26];
    assign i_bit    = Instruction[25];
    assign opcode   = Instruction[24:21];
    assign s_bit    = Instruction[20];
    assign rn       = Instruction[19:16];
    assign rd       = Instruction[15:12];
    assign is_dp    = (mode == 2'b00);
    assign is_mem   = (mode == 2'b01);
    assign is_br    = (mode == 2'b10);
    assign is_str   = is_mem && !s_bit;
    assign src2_sel = is_str ? rd : Instruction[3:0];
    assign two_src  = !i_bit || is_str;
    assign rn_used  = !is_br &&
                      !(is_dp && (opcode == 4'b1101 || opcode == 4'b1111));
    assign {fl_n, fl_z, fl_c, fl_v} = SR;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = fl_z;
            4'b0001: cond_ok = !fl_z;
            4'b0010: cond_ok = fl_c;
            4'b0011: cond_ok = !fl_c;
            4'b0100: cond_ok = fl_n;
            4'b0101: cond_ok = !fl_n;
            4'b0110: cond_ok = fl_v;
            4'b0111: cond_ok = !fl_v;
            4'b1000: cond_ok = fl_c && !fl_z;
            4'b1001: cond_ok = !fl_c || fl_z;
            4'b1010: cond_ok = (fl_n == fl_v);
            4'b1011: cond_ok = (fl_n != fl_v);
            4'b1100: cond_ok = !fl_z && (fl_n == fl_v);
            4'b1101: cond_ok = fl_z || (fl_n != fl_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_cmd = 4'b0000;
        case (opcode)
            4'b1101: alu_cmd = 4'b0001;
            4'b1111: alu_cmd = 4'b1001;
            4'b0100: alu_cmd = 4'b0010;
            4'b0101: alu_cmd = 4'b0011;
            4'b0010: alu_cmd = 4'b0100;
            4'b0110: alu_cmd = 4'b0101;
            4'b0000: alu_cmd = 4'b0110;
            4'b1100: alu_cmd = 4'b0111;
            4'b0001: alu_cmd = 4'b1000;
            4'b1010: alu_cmd = 4'b0100;
            4'b1000: alu_cmd = 4'b0110;
            default: alu_cmd = 4'b0000;
        endcase
    end

    always_comb begin
        exe_cmd = 4'b0000;
        wb_en   = 1'b0;
        mem_r   = 1'b0;
        mem_w   = 1'b0;
        br      = 1'b0;
        s_out   = 1'b0;
        unique case (1'b1)
            is_dp: begin
                exe_cmd = alu_cmd;
                wb_en   = !(opcode == 4'b1010 || opcode == 4'b1000);
                s_out   = s_bit;
            end
            is_mem: begin
                exe_cmd = 4'b0010;
                wb_en   = s_bit;
                mem_r   = s_bit;
                mem_w   = !s_bit;
                s_out   = s_bit;
            end
            is_br: begin
                br = 1'b1;
            end
            default: begin
                exe_cmd = 4'b0000;
            end
        endcase
    end

    // Write-through bypass: a same-cycle write-back wins over the stored value.
    always_comb begin
        val_rn = '0;
        val_rm = '0;
        if (rn <= LAST_REG) val_rn = rf_q[rn];
        if (src2_sel <= LAST_REG) val_rm = rf_q[src2_sel];
        if (WB_WB_EN && WB_Dest <= LAST_REG) begin
            if (WB_Dest == rn) val_rn = WB_Value;
            if (WB_Dest == src2_sel) val_rm = WB_Value;
        end
    end

`ifdef FORWARDING_EN
    logic unused_mem;
    assign unused_mem = ^{MEM_WB_EN, MEM_Dest};
    assign hit1 = EXE_WB_EN && EXE_MEM_R_EN && (EXE_Dest == rn);
    assign hit2 = EXE_WB_EN && EXE_MEM_R_EN && (EXE_Dest == src2_sel);
`else
    logic unused_ld;
    assign unused_ld = EXE_MEM_R_EN;
    assign hit1 = (EXE_WB_EN && EXE_Dest == rn) ||
                  (MEM_WB_EN && MEM_Dest == rn);
    assign hit2 = (EXE_WB_EN && EXE_Dest == src2_sel) ||
                  (MEM_WB_EN && MEM_Dest == src2_sel);
`endif

    assign raw    = (rn_used && hit1) || (two_src && hit2);
    assign hazard = rst && raw;

    always_comb begin
        id_ex_d        = '0;
        id_ex_d.pc     = PC_in;
        id_ex_d.cmd    = exe_cmd;
        id_ex_d.val_rn = val_rn;
        id_ex_d.val_rm = val_rm;
        id_ex_d.imm    = i_bit;
        id_ex_d.shift  = Instruction[11:0];
        id_ex_d.simm   = Instruction[23:0];
        id_ex_d.dest   = rd;
        id_ex_d.src1   = rn;
        id_ex_d.src2   = src2_sel;
        if (cond_ok && !raw) begin
            id_ex_d.wb_en = wb_en;
            id_ex_d.mem_r = mem_r;
            id_ex_d.mem_w = mem_w;
            id_ex_d.b     = br;
            id_ex_d.s     = s_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (WB_WB_EN && WB_Dest <= LAST_REG) begin
            rf_q[WB_Dest] <= WB_Value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q <= '0;
        end else if (flush) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign PC            = id_ex_q.pc;
    assign WB_EN         = id_ex_q.wb_en;
    assign MEM_R_EN      = id_ex_q.mem_r;
    assign MEM_W_EN      = id_ex_q.mem_w;
    assign B             = id_ex_q.b;
    assign S             = id_ex_q.s;
    assign EXE_CMD       = id_ex_q.cmd;
    assign Val_Rn        = id_ex_q.val_rn;
    assign Val_Rm        = id_ex_q.val_rm;
    assign imm           = id_ex_q.imm;
    assign Shift_operand = id_ex_q.shift;
    assign Signed_imm_24 = id_ex_q.simm;
    assign Dest          = id_ex_q.dest;
    assign src1          = id_ex_q.src1;
    assign src2          = id_ex_q.src2;

endmodule

// File: tb/tb_id_module.sv
// tb_id_module: directed and random decode checks against a behavioural model.
// Honours FORWARDING_EN the same way the design does.
`timescale 1ns/1ps
module tb_id_module;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush;
    logic [31:0] PC_in;
    logic [31:0] Instruction;
    logic [3:0]  SR;
    logic        WB_WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;
    logic        EXE_WB_EN;
    logic        MEM_WB_EN;
    logic [3:0]  EXE_Dest;
    logic [3:0]  MEM_Dest;
    logic        EXE_MEM_R_EN;
    logic        hazard;
    logic [31:0] PC;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic        B;
    logic        S;
    logic [3:0]  EXE_CMD;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        imm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [3:0]  Dest;
    logic [3:0]  src1;
    logic [3:0]  src2;

    int n_tests = 0;
    int n_fail  = 0;

    id_module dut (
        .clk(clk), .rst(rst), .flush(flush), .PC_in(PC_in),
        .Instruction(Instruction), .SR(SR), .WB_WB_EN(WB_WB_EN),
        .WB_Dest(WB_Dest), .WB_Value(WB_Value), .EXE_WB_EN(EXE_WB_EN),
        .MEM_WB_EN(MEM_WB_EN), .EXE_Dest(EXE_Dest), .MEM_Dest(MEM_Dest),
        .EXE_MEM_R_EN(EXE_MEM_R_EN), .hazard(hazard), .PC(PC),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B),
        .S(S), .EXE_CMD(EXE_CMD), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm),
        .imm(imm), .Shift_operand(Shift_operand),
        .Signed_imm_24(Signed_imm_24), .Dest(Dest), .src1(src1), .src2(src2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic [31:0] vrn, vrm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [3:0]  dest, s1, s2;
    } exp_t;

    logic [31:0] mrf [15];
    logic [3:0]  alu_tab [16];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] r);
        if (r == 4'd15) return 32'h0;
        if (WB_WB_EN && WB_Dest == r) return WB_Value;
        return mrf[r];
    endfunction

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit busy(input logic [3:0] r);
`ifdef FORWARDING_EN
        return EXE_WB_EN && EXE_MEM_R_EN && EXE_Dest == r;
`else
        return (EXE_WB_EN && EXE_Dest == r) || (MEM_WB_EN && MEM_Dest == r);
`endif
    endfunction

    function automatic logic [3:0] m_src2();
        bit store;
        store = Instruction[27:26] == 2'd1 && !Instruction[20];
        return store ? Instruction[15:12] : Instruction[3:0];
    endfunction

    function automatic bit model_hazard();
        logic [1:0] md;
        logic [3:0] op;
        bit store, uses_rn, uses_s2;
        md = Instruction[27:26];
        op = Instruction[24:21];
        store = md == 2'd1 && !Instruction[20];
        uses_rn = md != 2'd2 && !(md == 2'd0 && (op == 4'hD || op == 4'hF));
        uses_s2 = !Instruction[25] || store;
        return (uses_rn && busy(Instruction[19:16])) ||
               (uses_s2 && busy(m_src2()));
    endfunction

    function automatic exp_t model_next();
        exp_t e;
        logic [1:0] md;
        logic [3:0] op;
        e = '0;
        if (flush) return e;
        md = Instruction[27:26];
        op = Instruction[24:21];
        e.pc   = PC_in;
        e.vrn  = mread(Instruction[19:16]);
        e.vrm  = mread(m_src2());
        e.imm  = Instruction[25];
        e.sh   = Instruction[11:0];
        e.simm = Instruction[23:0];
        e.dest = Instruction[15:12];
        e.s1   = Instruction[19:16];
        e.s2   = m_src2();
        if (md == 2'd0) begin
            e.cmd = alu_tab[op];
            e.wb  = !(op == 4'b1010 || op == 4'b1000);
            e.s   = Instruction[20];
        end else if (md == 2'd1) begin
            e.cmd = 4'b0010;
            e.wb  = Instruction[20];
            e.mr  = Instruction[20];
            e.mw  = !Instruction[20];
            e.s   = Instruction[20];
        end else if (md == 2'd2) begin
            e.b = 1'b1;
        end
        if (!cond_pass(Instruction[31:28], SR) || model_hazard()) begin
            {e.wb, e.mr, e.mw, e.b, e.s} = '0;
        end
        return e;
    endfunction

    task automatic check_out(input exp_t e);
        check("PC", PC, e.pc);
        check("WB_EN", WB_EN, e.wb);
        check("MEM_R_EN", MEM_R_EN, e.mr);
        check("MEM_W_EN", MEM_W_EN, e.mw);
        check("B", B, e.b);
        check("S", S, e.s);
        check("EXE_CMD", EXE_CMD, e.cmd);
        check("Val_Rn", Val_Rn, e.vrn);
        check("Val_Rm", Val_Rm, e.vrm);
        check("imm", imm, e.imm);
        check("Shift_operand", Shift_operand, e.sh);
        check("Signed_imm_24", Signed_imm_24, e.simm);
        check("Dest", Dest, e.dest);
        check("src1", src1, e.s1);
        check("src2", src2, e.s2);
    endtask

    task automatic step();
        exp_t e;
        #1;
        check("hazard", hazard, model_hazard());
        e = model_next();
        @(posedge clk);
        if (WB_WB_EN && WB_Dest != 4'd15) mrf[WB_Dest] = WB_Value;
        #1;
        check_out(e);
        @(negedge clk);
    endtask

    task automatic idle();
        flush        = 1'b0;
        PC_in        = 32'h100;
        Instruction  = 32'hE1A00000;
        SR           = 4'b0000;
        WB_WB_EN     = 1'b0;
        WB_Dest      = 4'd0;
        WB_Value     = 32'h0;
        EXE_WB_EN    = 1'b0;
        MEM_WB_EN    = 1'b0;
        EXE_Dest     = 4'd0;
        MEM_Dest     = 4'd0;
        EXE_MEM_R_EN = 1'b0;
    endtask

    task automatic rand_inputs();
        logic [31:0] r;
        logic [3:0]  c;
        r = $urandom;
        c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
        Instruction  = {c, r[27:0]};
        PC_in        = $urandom;
        SR           = 4'($urandom);
        flush        = ($urandom_range(0, 9) == 0);
        WB_WB_EN     = 1'($urandom);
        WB_Dest      = 4'($urandom);
        WB_Value     = $urandom;
        EXE_WB_EN    = 1'($urandom);
        MEM_WB_EN    = 1'($urandom);
        EXE_Dest     = 4'($urandom);
        MEM_Dest     = 4'($urandom);
        EXE_MEM_R_EN = 1'($urandom);
    endtask

    initial begin
        bit exp_hz;
        for (int i = 0; i < 16; i++) alu_tab[i] = 4'b0000;
        alu_tab[4'b1101] = 4'b0001;
        alu_tab[4'b1111] = 4'b1001;
        alu_tab[4'b0100] = 4'b0010;
        alu_tab[4'b0101] = 4'b0011;
        alu_tab[4'b0010] = 4'b0100;
        alu_tab[4'b0110] = 4'b0101;
        alu_tab[4'b0000] = 4'b0110;
        alu_tab[4'b1100] = 4'b0111;
        alu_tab[4'b0001] = 4'b1000;
        alu_tab[4'b1010] = 4'b0100;
        alu_tab[4'b1000] = 4'b0110;
        for (int i = 0; i < 15; i++) mrf[i] = 32'h0;

        idle();
        EXE_WB_EN = 1'b1;
        Instruction = 32'hE0800000;
        repeat (2) @(negedge clk);
        check("rst_hazard", hazard, 1'b0);
        check_out('0);
        rst = 1'b1;
        idle();

        WB_WB_EN = 1'b1; WB_Dest = 4'd3; WB_Value = 32'h1234;
        step();
        idle();
        Instruction = 32'hE0831003; PC_in = 32'h104;
        step();
        check("t2_Val_Rn", Val_Rn, 32'h1234);
        check("t2_Val_Rm", Val_Rm, 32'h1234);
        check("t2_EXE_CMD", EXE_CMD, 4'b0010);
        check("t2_WB_EN", WB_EN, 1'b1);
        check("t2_Dest", Dest, 4'd1);

        idle();
        WB_WB_EN = 1'b1; WB_Dest = 4'd2; WB_Value = 32'hAA;
        Instruction = 32'hE1A00002;
        step();
        check("t3_bypass", Val_Rm, 32'hAA);
        check("t3_EXE_CMD", EXE_CMD, 4'b0001);

        idle();
        Instruction = 32'h00811002;
        step();
        check("t4_ctrl", {WB_EN, MEM_R_EN, MEM_W_EN, B, S}, 5'b0);
        check("t4_Dest", Dest, 4'd1);
        check("t4_Val_Rm", Val_Rm, 32'hAA);

        idle();
        EXE_WB_EN = 1'b1; EXE_Dest = 4'd1;
        Instruction = 32'hE2812005;
`ifdef FORWARDING_EN
        exp_hz = 1'b0;
`else
        exp_hz = 1'b1;
`endif
        #1;
        check("t5_hazard", hazard, exp_hz);
        step();
        check("t5_WB_EN", WB_EN, !exp_hz);

        idle();
        EXE_WB_EN = 1'b1; EXE_Dest = 4'd4; EXE_MEM_R_EN = 1'b1;
        Instruction = 32'hE5854000; flush = 1'b1;
        #1;
        check("t6_hazard", hazard, 1'b1);
        step();
        check("t6_flush_all", {PC, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
              Dest, src1, src2, imm, Shift_operand}, '0);
        idle();
        Instruction = 32'hE5854000;
        step();
        check("t6_MEM_W_EN", MEM_W_EN, 1'b1);
        check("t6_src2", src2, 4'd4);
        check("t6_WB_EN", WB_EN, 1'b0);

        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            step();
        end

        idle();
        Instruction = 32'hE1A01002; PC_in = 32'h5A5A;
        step();
        EXE_WB_EN = 1'b1; EXE_Dest = 4'd2; EXE_MEM_R_EN = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_hazard", hazard, 1'b0);
        check_out('0);
        for (int i = 0; i < 15; i++) mrf[i] = 32'h0;
        @(posedge clk);
        #1;
        check_out('0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            idle();
            Instruction = 32'hE0800000 | (32'(i) << 16) | 32'(i);
            step();
            check("rf_cleared", Val_Rn, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
